// File: rtl/relu_pool_ctrl_if.sv
// Handshake and buffer bus between the ReLU/pool sequencer and its neighbours:
// the conv output RAM, the pool unit and the pooled-map RAM.
interface relu_pool_ctrl_if #(
   parameter int AW  = 13,
   parameter int OAW = 11
);
   logic           start;
   logic           busy;
   logic           done;
   logic           rd_en;
   logic [AW-1:0]  rd_addr;
   logic [15:0]    rd_data;
   logic           pool_vld;
   logic [15:0]    pool_num1;
   logic [15:0]    pool_num2;
   logic [15:0]    pool_num3;
   logic [15:0]    pool_num4;
   logic           pool_dout_vld;
   logic [7:0]     pool_dout;
   logic           wr_en;
   logic [OAW-1:0] wr_addr;
   logic [7:0]     wr_data;

   modport master (
      input  start, rd_data, pool_dout_vld, pool_dout,
      output busy, done, rd_en, rd_addr, pool_vld,
             pool_num1, pool_num2, pool_num3, pool_num4,
             wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, rd_data, pool_dout_vld, pool_dout,
      input  busy, done, rd_en, rd_addr, pool_vld,
             pool_num1, pool_num2, pool_num3, pool_num4,
             wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/relu_pool_ctrl.sv
// Walks every 2x2 window of a channel-major conv map, feeds the four operands to
// the ReLU/max-pool unit and stores each pooled byte at the linear window index.
module relu_pool_ctrl #(
   parameter int IN_W = 28,
   parameter int IN_H = 28,
   parameter int CH   = 6,
   parameter int AW   = 13,
   parameter int OAW  = 11
) (
   input  logic             clk,
   input  logic             rst,
   relu_pool_ctrl_if.master bus
);
   localparam int OW = IN_W / 2;
   localparam int OH = IN_H / 2;
   localparam int XW = (OW > 1) ? $clog2(OW) : 1;
   localparam int YW = (OH > 1) ? $clog2(OH) : 1;
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_LAST, S_POOL, S_WR, S_DONE} state_t;

   state_t         state, state_nx;
   logic [1:0]     idx;
   logic [AW-1:0]  base;
   logic [AW-1:0]  offs;
   logic [XW-1:0]  ox;
   logic [YW-1:0]  oy;
   logic [CW-1:0]  c;
   logic [OAW-1:0] widx;
   logic [15:0]    num1, num2, num3, num4;
   logic [7:0]     wr_data_q;
   logic           ox_last, oy_last, last_win;

   assign ox_last  = (ox == XW'(OW - 1));
   assign oy_last  = (oy == YW'(OH - 1));
   assign last_win = ox_last && oy_last && (c == CW'(CH - 1));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (bus.start) state_nx = S_RD;
         S_RD:   if (idx == 2'd3) state_nx = S_LAST;
         S_LAST: state_nx = S_POOL;
         S_POOL: if (bus.pool_dout_vld) state_nx = S_WR;
         S_WR:   state_nx = last_win ? S_DONE : S_RD;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand order within the window: top-left, top-right, bottom-left, bottom-right.
   always_comb begin
      offs = '0;
      case (idx)
         2'd0: offs = AW'(0);
         2'd1: offs = AW'(1);
         2'd2: offs = AW'(IN_W);
         2'd3: offs = AW'(IN_W + 1);
         default: offs = '0;
      endcase
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.rd_en     = (state == S_RD);
   assign bus.rd_addr   = (state == S_RD) ? (base + offs) : '0;
   assign bus.pool_vld  = (state == S_POOL);
   assign bus.wr_en     = (state == S_WR);
   assign bus.wr_addr   = (state == S_WR) ? widx : '0;
   assign bus.wr_data   = wr_data_q;
   assign bus.pool_num1 = num1;
   assign bus.pool_num2 = num2;
   assign bus.pool_num3 = num3;
   assign bus.pool_num4 = num4;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         base      <= '0;
         ox        <= '0;
         oy        <= '0;
         c         <= '0;
         widx      <= '0;
         num1      <= '0;
         num2      <= '0;
         num3      <= '0;
         num4      <= '0;
         wr_data_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (bus.start) begin
               idx  <= '0;
               base <= '0;
               ox   <= '0;
               oy   <= '0;
               c    <= '0;
               widx <= '0;
            end
            S_RD: begin
               idx <= idx + 2'd1;
               // rd_data holds the operand addressed on the previous cycle
               case (idx)
                  2'd1: num1 <= bus.rd_data;
                  2'd2: num2 <= bus.rd_data;
                  2'd3: num3 <= bus.rd_data;
                  default: ;
               endcase
            end
            S_LAST: num4 <= bus.rd_data;
            S_POOL: if (bus.pool_dout_vld) wr_data_q <= bus.pool_dout;
            S_WR: begin
               widx <= widx + OAW'(1);
               // Row and channel steps land on the same +IN_W+2 base delta.
               base <= base + (ox_last ? AW'(IN_W + 2) : AW'(2));
               if (ox_last) begin
                  ox <= '0;
                  if (oy_last) begin
                     oy <= '0;
                     c  <= c + CW'(1);
                  end else begin
                     oy <= oy + YW'(1);
                  end
               end else begin
                  ox <= ox + XW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_relu_pool_ctrl.sv
// Directed bench: two small controllers (4x4x1 and 4x4x2) with a conv buffer
// model and a ReLU/max/round pool model whose output latency can be stretched.
module tb_relu_pool_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   relu_pool_ctrl_if #(.AW(13), .OAW(11)) ia ();
   relu_pool_ctrl_if #(.AW(13), .OAW(11)) ib ();

   relu_pool_ctrl #(.IN_W(4), .IN_H(4), .CH(1), .AW(13), .OAW(11))
      dut_a (.clk(clk), .rst(rst_a), .bus(ia.master));
   relu_pool_ctrl #(.IN_W(4), .IN_H(4), .CH(2), .AW(13), .OAW(11))
      dut_b (.clk(clk), .rst(rst_b), .bus(ib.master));

   logic [15:0] mem_a [16];
   logic [15:0] mem_b [32];
   int stall_a = -1;
   int base_seq [16] = '{0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15};

   function automatic logic [7:0] pool_f(input logic [15:0] a, b, c, d);
      int m, v;
      m = 0;
      v = int'($signed(a)); if (v > m) m = v;
      v = int'($signed(b)); if (v > m) m = v;
      v = int'($signed(c)); if (v > m) m = v;
      v = int'($signed(d)); if (v > m) m = v;
      m = (m + 64) >>> 7;
      if (m > 255) m = 255;
      return m[7:0];
   endfunction

   // Buffers with one-cycle read latency; pool models raise dout_vld on the
   // 4th edge with pool_vld high (plus 7 more in the stalled window).
   int pc_a = 0, win_a = 0, pc_b = 0;
   logic pv_a_d = 1'b0;
   always @(posedge clk) begin
      if (ia.rd_en) ia.rd_data <= mem_a[ia.rd_addr[3:0]];
      if (ib.rd_en) ib.rd_data <= mem_b[ib.rd_addr[4:0]];
      if (ia.start && !ia.busy) win_a <= 0;
      else if (pv_a_d && !ia.pool_vld) win_a <= win_a + 1;
      pv_a_d <= ia.pool_vld;
      if (!ia.pool_vld) begin
         pc_a <= 0; ia.pool_dout_vld <= 1'b0; ia.pool_dout <= 8'd0;
      end else begin
         pc_a <= pc_a + 1;
         if (pc_a == 3 + ((win_a == stall_a) ? 7 : 0)) begin
            ia.pool_dout_vld <= 1'b1;
            ia.pool_dout <= pool_f(ia.pool_num1, ia.pool_num2, ia.pool_num3, ia.pool_num4);
         end
      end
      if (!ib.pool_vld) begin
         pc_b <= 0; ib.pool_dout_vld <= 1'b0; ib.pool_dout <= 8'd0;
      end else begin
         pc_b <= pc_b + 1;
         if (pc_b == 3) begin
            ib.pool_dout_vld <= 1'b1;
            ib.pool_dout <= pool_f(ib.pool_num1, ib.pool_num2, ib.pool_num3, ib.pool_num4);
         end
      end
   end

   logic any_a, any_b;
   assign any_a = ia.busy | ia.done | ia.rd_en | (|ia.rd_addr) | ia.pool_vld | (|ia.pool_num1) |
                  (|ia.pool_num2) | (|ia.pool_num3) | (|ia.pool_num4) | ia.wr_en | (|ia.wr_addr) | (|ia.wr_data);
   assign any_b = ib.busy | ib.done | ib.rd_en | (|ib.rd_addr) | ib.pool_vld | (|ib.pool_num1) |
                  (|ib.pool_num2) | (|ib.pool_num3) | (|ib.pool_num4) | ib.wr_en | (|ib.wr_addr) | (|ib.wr_data);

   bit sel = 1'b0;
   logic        m_busy, m_done, m_rd_en, m_pool_vld, m_wr_en, m_any;
   logic [12:0] m_rd_addr;
   logic [10:0] m_wr_addr;
   logic [7:0]  m_wr_data;
   logic [15:0] m_num [4];
   assign m_busy     = sel ? ib.busy     : ia.busy;
   assign m_done     = sel ? ib.done     : ia.done;
   assign m_rd_en    = sel ? ib.rd_en    : ia.rd_en;
   assign m_pool_vld = sel ? ib.pool_vld : ia.pool_vld;
   assign m_wr_en    = sel ? ib.wr_en    : ia.wr_en;
   assign m_rd_addr  = sel ? ib.rd_addr  : ia.rd_addr;
   assign m_wr_addr  = sel ? ib.wr_addr  : ia.wr_addr;
   assign m_wr_data  = sel ? ib.wr_data  : ia.wr_data;
   assign m_any      = sel ? any_b       : any_a;
   assign m_num[0]   = sel ? ib.pool_num1 : ia.pool_num1;
   assign m_num[1]   = sel ? ib.pool_num2 : ia.pool_num2;
   assign m_num[2]   = sel ? ib.pool_num3 : ia.pool_num3;
   assign m_num[3]   = sel ? ib.pool_num4 : ia.pool_num4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] memrd(input bit w, input int a);
      return w ? mem_b[a[4:0]] : mem_a[a[3:0]];
   endfunction

   task automatic set_start(input bit w, input logic v);
      if (w) ib.start = v; else ia.start = v;
   endtask

   int rd_log[$], wa_log[$], wd_log[$], pv_len[$];
   int first_rd, done_cyc, done_cnt;
   bit excl_ok, stab_ok, num_ok;

   task automatic run_pass(input bit w, input int abort_win, input bit inject);
      int cyc, cur_len, n;
      bit prev_pv;
      logic [15:0] pn [4];
      rd_log.delete(); wa_log.delete(); wd_log.delete(); pv_len.delete();
      first_rd = -1; done_cyc = -1; done_cnt = 0;
      excl_ok = 1; stab_ok = 1; num_ok = 1;
      cyc = 0; cur_len = 0; prev_pv = 0;
      sel = w;
      @(negedge clk);
      set_start(w, 1'b1);
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (m_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            rd_log.push_back(int'(m_rd_addr));
            if (m_wr_en || m_pool_vld) excl_ok = 0;
         end
         if (m_wr_en && m_pool_vld) excl_ok = 0;
         if (m_pool_vld && !prev_pv) begin
            n = rd_log.size();
            if (n < 4) num_ok = 0;
            else for (int k = 0; k < 4; k++) if (m_num[k] !== memrd(w, rd_log[n-4+k])) num_ok = 0;
         end
         if (m_pool_vld && prev_pv)
            for (int k = 0; k < 4; k++) if (m_num[k] !== pn[k]) stab_ok = 0;
         for (int k = 0; k < 4; k++) pn[k] = m_num[k];
         if (m_pool_vld) cur_len++;
         else if (prev_pv) begin pv_len.push_back(cur_len); cur_len = 0; end
         prev_pv = m_pool_vld;
         if (m_wr_en) begin
            wa_log.push_back(int'(m_wr_addr));
            wd_log.push_back(int'(m_wr_data));
         end
         if (m_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (abort_win >= 0 && m_pool_vld && wa_log.size() == abort_win) begin
            set_start(w, 1'b0);
            if (w) rst_b = 1'b0; else rst_a = 1'b0;
            @(negedge clk);
            chk("abort_outputs_zero", {31'd0, m_any}, 32'd0);
            chk("abort_no_extra_write", wa_log.size(), abort_win);
            if (w) rst_b = 1'b1; else rst_a = 1'b1;
            return;
         end
         set_start(w, inject && (cyc == 3 || cyc == 20 || cyc == 50 || m_done));
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      set_start(w, 1'b0);
   endtask

   task automatic check_pass(input string tg, input int nwin, input int exp_wd [8], input int stall_w);
      chk($sformatf("%s_nrd", tg), rd_log.size(), nwin * 4);
      for (int i = 0; i < nwin * 4 && i < rd_log.size(); i++)
         chk($sformatf("%s_rd_addr[%0d]", tg, i), rd_log[i], (i / 16) * 16 + base_seq[i % 16]);
      chk($sformatf("%s_nwr", tg), wa_log.size(), nwin);
      for (int i = 0; i < nwin && i < wa_log.size(); i++) begin
         chk($sformatf("%s_wr_addr[%0d]", tg, i), wa_log[i], i);
         chk($sformatf("%s_wr_data[%0d]", tg, i), wd_log[i], exp_wd[i]);
      end
      for (int i = 0; i < nwin && i < pv_len.size(); i++)
         chk($sformatf("%s_pool_len[%0d]", tg, i), pv_len[i], (i == stall_w) ? 12 : 5);
      chk($sformatf("%s_done_lat", tg), done_cyc - first_rd, nwin * 11 + ((stall_w >= 0) ? 7 : 0));
      chk($sformatf("%s_done_cnt", tg), done_cnt, 1);
      chk($sformatf("%s_rd_wr_pool_excl", tg), {31'd0, excl_ok}, 1);
      chk($sformatf("%s_num_stable", tg), {31'd0, stab_ok}, 1);
      chk($sformatf("%s_num_values", tg), {31'd0, num_ok}, 1);
   endtask

   initial begin
      bit idle_ok;
      int wd_base [8]  = '{5, 7, 13, 15, 0, 0, 0, 0};
      int wd_neg  [8]  = '{0, 1, 13, 15, 0, 0, 0, 0};
      int wd_mc   [8]  = '{5, 7, 13, 15, 21, 23, 29, 31};
      ia.start = 1'b0;
      ib.start = 1'b0;
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i * 128);
      for (int i = 0; i < 32; i++) mem_b[i] = 16'(i * 128);

      // reset and idle
      repeat (3) @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      idle_ok = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (any_a !== 1'b0 || any_b !== 1'b0) idle_ok = 0;
      end
      chk("reset_idle_outputs_zero", {31'd0, idle_ok}, 1);

      // single pass, 4x4x1
      run_pass(1'b0, -1, 1'b0);
      check_pass("base", 4, wd_base, -1);

      // negatives, round-half-up and a stretched pool latency in window 1
      mem_a[0] = 16'hFF00; mem_a[1] = 16'hFF80; mem_a[4] = 16'hFFFF; mem_a[5] = 16'hFED4;
      mem_a[2] = 16'd64;   mem_a[3] = 16'd63;   mem_a[6] = 16'hFF38; mem_a[7] = 16'd0;
      stall_a = 1;
      run_pass(1'b0, -1, 1'b0);
      check_pass("relu_stall", 4, wd_neg, 1);
      stall_a = -1;
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i * 128);

      // two channels with start pulses while busy and during DONE
      run_pass(1'b1, -1, 1'b1);
      check_pass("multi_ch", 8, wd_mc, -1);
      chk("multi_ch_idle_after_done", {31'd0, ib.busy}, 0);

      // abort in window 2's POOL, then a clean rerun
      run_pass(1'b0, 2, 1'b0);
      run_pass(1'b0, -1, 1'b0);
      check_pass("rerun", 4, wd_base, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
